// File: rtl/cv32e40px_core_v_xif_pkg.sv
// rtl/cv32e40px_core_v_xif_pkg.sv - shared types for the coprocessor result writeback path
package cv32e40px_core_v_xif_pkg;

  localparam int unsigned X_RESULT_WE_W   = 2;
  localparam int unsigned X_RESULT_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } x_wb_state_e;

  // Entries always carry the dual-write width; single-write builds leave the top half zero.
  typedef struct packed {
    logic [3:0]                   id;
    logic [4:0]                   rd;
    logic [X_RESULT_WE_W-1:0]     we;
    logic [X_RESULT_DATA_W-1:0]   data;
  } x_result_entry_t;

  localparam int unsigned X_RESULT_ENTRY_W = $bits(x_result_entry_t);

  function automatic logic [4:0] rd_pair(input logic [4:0] rd);
    return rd | 5'd1;
  endfunction

endpackage

// File: rtl/cv32e40px_x_result_fifo.sv
// rtl/cv32e40px_x_result_fifo.sv - generic synchronous FIFO with wrap-around pointers and occupancy count
module cv32e40px_x_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Guard both sides so a stray push/pop can never corrupt the count.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40px_x_result_wb.sv
// rtl/cv32e40px_x_result_wb.sv - buffers coprocessor results and writes them back around core WB; optional CV32E40PX_X_RESULT_BYPASS_EN
module cv32e40px_x_result_wb
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_DUALWRITE = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          x_result_valid_i,
  output logic                          x_result_ready_o,
  input  logic [3:0]                    x_result_id_i,
  input  logic [4:0]                    x_result_rd_i,
  input  logic [X_DUALWRITE:0]          x_result_we_i,
  input  logic [32*(X_DUALWRITE+1)-1:0] x_result_data_i,
  input  logic                          core_wb_we_i,
  output logic                          rf_we_o,
  output logic [4:0]                    rf_waddr_o,
  output logic [31:0]                   rf_wdata_o,
  output logic                          sb_clr_valid_o,
  output logic [4:0]                    sb_clr_rd_o,
  output logic [X_DUALWRITE:0]          sb_clr_we_o,
  output logic                          empty_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic        DUAL_EN = (X_DUALWRITE != 0);

  x_wb_state_e     state_q, state_d;
  x_result_entry_t in_entry;
  x_result_entry_t head;
  logic [X_RESULT_ENTRY_W-1:0] head_raw;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            accept;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            port_free;
  logic            head_dual;
  logic            more_pending;
  logic            unused_id;

  assign in_entry.id   = x_result_id_i;
  assign in_entry.rd   = x_result_rd_i;
  assign in_entry.we   = X_RESULT_WE_W'(x_result_we_i);
  assign in_entry.data = X_RESULT_DATA_W'(x_result_data_i);

  assign x_result_ready_o = ~fifo_full;
  assign accept           = x_result_valid_i & x_result_ready_o;

`ifdef CV32E40PX_X_RESULT_BYPASS_EN
  assign bypass = accept & fifo_empty & (state_q == IDLE) & ~core_wb_we_i & ~in_entry.we[1];
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass;

  cv32e40px_x_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (X_RESULT_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head      = x_result_entry_t'(head_raw);
  assign unused_id = ^head.id;
  assign port_free = ~core_wb_we_i;
  // An entry with we[0]=0 writes nothing, so it never visits WR_HI.
  assign head_dual = DUAL_EN & head.we[0] & head.we[1];
  // Counted before this cycle's pop lands, so >1 means something is behind the head.
  assign more_pending = (fifo_count > CW'(1)) | push;
  assign empty_o      = fifo_empty & (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty || push) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (port_free) begin
          if (head_dual) begin
            state_d = WR_HI;
          end else begin
            state_d = more_pending ? WR_LO : IDLE;
          end
        end
      end
      WR_HI: begin
        if (port_free) begin
          state_d = more_pending ? WR_LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop            = 1'b0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    sb_clr_valid_o = 1'b0;
    sb_clr_rd_o    = '0;
    sb_clr_we_o    = '0;
    case (state_q)
      IDLE: begin
        if (bypass) begin
          rf_we_o        = (x_result_rd_i != 5'd0) & in_entry.we[0];
          rf_waddr_o     = x_result_rd_i;
          rf_wdata_o     = in_entry.data[31:0];
          sb_clr_valid_o = 1'b1;
          sb_clr_rd_o    = x_result_rd_i;
          sb_clr_we_o    = x_result_we_i;
        end
      end
      WR_LO: begin
        pop            = port_free & ~head_dual;
        rf_we_o        = port_free & head.we[0] & (head.rd != 5'd0);
        rf_waddr_o     = head.rd;
        rf_wdata_o     = head.data[31:0];
        sb_clr_valid_o = pop;
        sb_clr_rd_o    = head.rd;
        sb_clr_we_o    = head.we[X_DUALWRITE:0];
      end
      WR_HI: begin
        pop            = port_free;
        rf_we_o        = port_free;
        rf_waddr_o     = rd_pair(head.rd);
        rf_wdata_o     = head.data[63:32];
        sb_clr_valid_o = port_free;
        sb_clr_rd_o    = head.rd;
        sb_clr_we_o    = head.we[X_DUALWRITE:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cv32e40px_x_result_wb.sv
// tb/tb_cv32e40px_x_result_wb.sv - scoreboard bench for the coprocessor result writeback block
module tb_cv32e40px_x_result_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic [3:0]  x_result_id_i;
  logic [4:0]  x_result_rd_i;
  logic [1:0]  x_result_we_i;
  logic [63:0] x_result_data_i;
  logic        core_wb_we_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        sb_clr_valid_o;
  logic [4:0]  sb_clr_rd_o;
  logic [1:0]  sb_clr_we_o;
  logic        empty_o;

  cv32e40px_x_result_wb #(
    .DEPTH       (4),
    .X_DUALWRITE (1)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_id_i    (x_result_id_i),
    .x_result_rd_i    (x_result_rd_i),
    .x_result_we_i    (x_result_we_i),
    .x_result_data_i  (x_result_data_i),
    .core_wb_we_i     (core_wb_we_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .sb_clr_valid_o   (sb_clr_valid_o),
    .sb_clr_rd_o      (sb_clr_rd_o),
    .sb_clr_we_o      (sb_clr_we_o),
    .empty_o          (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [4:0] rd; logic [1:0] we; } clr_t;

  wr_t  wr_q[$];
  clr_t clr_q[$];
  int   tests_run = 0;
  int   fails = 0;
  logic saw_wr, saw_clr, saw_acc;

  // One clock: sample at negedge (inputs final), push expectations on accept, check outputs.
  task automatic step();
    wr_t  ew;
    clr_t ec;
    @(negedge clk);
    saw_wr  = rf_we_o;
    saw_clr = sb_clr_valid_o;
    saw_acc = x_result_valid_i && x_result_ready_o && rst_n;
    if (saw_acc) begin
      if (x_result_we_i[0] && x_result_rd_i != 5'd0)
        wr_q.push_back('{x_result_rd_i, x_result_data_i[31:0]});
      if (x_result_we_i[0] && x_result_we_i[1])
        wr_q.push_back('{x_result_rd_i | 5'd1, x_result_data_i[63:32]});
      clr_q.push_back('{x_result_rd_i, x_result_we_i});
    end
    if (rf_we_o) begin
      tests_run++;
      if (wr_q.size() == 0 || core_wb_we_i) begin
        fails++;
        $display("FAIL rf_write unexpected: addr=%0d data=%h core_wb=%b", rf_waddr_o, rf_wdata_o, core_wb_we_i);
      end else begin
        ew = wr_q.pop_front();
        if (rf_waddr_o !== ew.a || rf_wdata_o !== ew.d) begin
          fails++;
          $display("FAIL rf_write: got addr=%0d data=%h, want addr=%0d data=%h", rf_waddr_o, rf_wdata_o, ew.a, ew.d);
        end
      end
    end
    if (sb_clr_valid_o) begin
      tests_run++;
      if (clr_q.size() == 0) begin
        fails++;
        $display("FAIL sb_clr unexpected: rd=%0d we=%b", sb_clr_rd_o, sb_clr_we_o);
      end else begin
        ec = clr_q.pop_front();
        if (sb_clr_rd_o !== ec.rd || sb_clr_we_o !== ec.we) begin
          fails++;
          $display("FAIL sb_clr: got rd=%0d we=%b, want rd=%0d we=%b", sb_clr_rd_o, sb_clr_we_o, ec.rd, ec.we);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_result(input logic [4:0] rd, input logic [1:0] we, input logic [63:0] data);
    x_result_valid_i = 1'b1;
    x_result_id_i    = rd[3:0];
    x_result_rd_i    = rd;
    x_result_we_i    = we;
    x_result_data_i  = data;
  endtask

  task automatic send(input logic [4:0] rd, input logic [1:0] we, input logic [63:0] data);
    int n;
    set_result(rd, we, data);
    n = 0;
    do begin
      step();
      n++;
    end while (!saw_acc && n < 50);
    x_result_valid_i = 1'b0;
    tests_run++;
    if (!saw_acc) begin
      fails++;
      $display("FAIL accept_timeout: rd=%0d not accepted within %0d cycles", rd, n);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || clr_q.size() != 0 || !empty_o) && n < 60) begin
      step();
      n++;
    end
    tests_run++;
    if (wr_q.size() != 0 || clr_q.size() != 0 || empty_o !== 1'b1) begin
      fails++;
      $display("FAIL %s drain: pending writes=%0d clears=%0d empty=%b, want 0 0 1", name, wr_q.size(), clr_q.size(), empty_o);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (x_result_ready_o !== 1'b1 || rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 ||
        sb_clr_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: ready=%b we=%b addr=%0d data=%h clr=%b empty=%b, want 1 0 0 0 0 1",
               x_result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o, empty_o);
    end
  endtask

  task automatic test_single();
    core_wb_we_i = 1'b0;
    set_result(5'd5, 2'b01, 64'h0000_0000_DEAD_BEEF);
    step();
    x_result_valid_i = 1'b0;
`ifndef CV32E40PX_X_RESULT_BYPASS_EN
    step();
`endif
    tests_run++;
    if (saw_wr !== 1'b1 || saw_clr !== 1'b1) begin
      fails++;
      $display("FAIL single_latency: write=%b clear=%b, want 1 1", saw_wr, saw_clr);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    int  writes;
    logic fifth_in;
    core_wb_we_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_result(5'(10 + i), 2'b01, 64'(32'hA000_0000 + i));
      step();
      tests_run++;
      if (saw_acc !== (i < 4)) begin
        fails++;
        $display("FAIL b2b_ready[%0d]: accepted=%b, want %b", i, saw_acc, (i < 4));
      end
    end
    core_wb_we_i = 1'b0;
    writes = 0;
    fifth_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (saw_wr) writes++;
      if (saw_acc) begin
        fifth_in = 1'b1;
        x_result_valid_i = 1'b0;
      end
    end
    tests_run++;
    if (writes != 4) begin
      fails++;
      $display("FAIL b2b_writes: got %0d writes in 4 cycles, want 4", writes);
    end
    if (!fifth_in) send(5'd14, 2'b01, 64'hA000_0004);
    x_result_valid_i = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_dual();
    core_wb_we_i = 1'b0;
    send(5'd6, 2'b11, 64'h1111_2222_3333_4444);
    drain("dual");
  endtask

  task automatic test_rd_zero();
    send(5'd0, 2'b01, 64'h0000_0000_5555_AAAA);
    drain("rd_zero");
    send(5'd9, 2'b00, 64'h0000_0000_1234_5678);
    drain("no_we");
  endtask

  task automatic test_hold_hi();
    core_wb_we_i = 1'b0;
    send(5'd12, 2'b11, 64'hCAFE_F00D_0BAD_BEEF);
    step();
    tests_run++;
    if (saw_wr !== 1'b1 || saw_clr !== 1'b0) begin
      fails++;
      $display("FAIL hold_lo: write=%b clear=%b, want 1 0", saw_wr, saw_clr);
    end
    core_wb_we_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (saw_wr !== 1'b0 || saw_clr !== 1'b0) begin
        fails++;
        $display("FAIL hold_busy[%0d]: write=%b clear=%b, want 0 0", i, saw_wr, saw_clr);
      end
    end
    core_wb_we_i = 1'b0;
    step();
    tests_run++;
    if (saw_wr !== 1'b1 || saw_clr !== 1'b1) begin
      fails++;
      $display("FAIL hold_hi: write=%b clear=%b, want 1 1", saw_wr, saw_clr);
    end
    drain("hold_hi");
  endtask

  task automatic test_reset_mid();
    core_wb_we_i = 1'b1;
    send(5'd14, 2'b11, 64'h7777_8888_9999_AAAA);
    send(5'd16, 2'b01, 64'h0000_0000_0000_0016);
    send(5'd17, 2'b01, 64'h0000_0000_0000_0017);
    send(5'd18, 2'b01, 64'h0000_0000_0000_0018);
    core_wb_we_i = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    wr_q.delete();
    clr_q.delete();
    #1;
    tests_run++;
    if (empty_o !== 1'b1 || x_result_ready_o !== 1'b1 || rf_we_o !== 1'b0 || sb_clr_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: empty=%b ready=%b we=%b clr=%b, want 1 1 0 0",
               empty_o, x_result_ready_o, rf_we_o, sb_clr_valid_o);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    drain("reset_mid");
  endtask

  initial begin
    rst_n            = 1'b0;
    x_result_valid_i = 1'b0;
    x_result_id_i    = '0;
    x_result_rd_i    = '0;
    x_result_we_i    = '0;
    x_result_data_i  = '0;
    core_wb_we_i     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_single();
    test_back_to_back();
    test_dual();
    test_rd_zero();
    test_hold_hi();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
